// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed hex display for the CPU debug fields.
// The selected field is snapshotted once per frame, so the digits never tear.
module seg7_scan_display #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  disp_clock_count,
    input  logic [8:0]  pc,
    input  logic [31:0] reg_value,
    input  logic [1:0]  sel,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  disp_anode,
    output logic [7:0]  disp_seg,
    output logic        frame_tick
);

    localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0] pre_reg, pre_next;
    logic [1:0]       digit_reg, digit_next;
    logic [15:0]      snap_reg, snap_next;
    logic             active_reg, active_next;
    logic             tick_reg, tick_next;
    logic [15:0]      field;
    logic [6:0]       digit_seg [4];

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        case (sel)
            2'd0:    field = reg_value[15:0];
            2'd1:    field = reg_value[31:16];
            2'd2:    field = {7'b0, pc};
            default: field = {8'b0, disp_clock_count};
        endcase
    end

    // The first cycle after reset only primes the snapshot; the scan then starts at digit 0.
    always_comb begin
        pre_next    = pre_reg;
        digit_next  = digit_reg;
        snap_next   = snap_reg;
        active_next = active_reg;
        tick_next   = 1'b0;
        if (!active_reg) begin
            snap_next   = field;
            active_next = 1'b1;
            tick_next   = 1'b1;
        end else if (pre_reg == PRE_LAST) begin
            pre_next   = '0;
            digit_next = digit_reg + 2'd1;
            if (digit_reg == 2'd3) begin
                snap_next = field;
                tick_next = 1'b1;
            end
        end else begin
            pre_next = pre_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pre_reg    <= '0;
            digit_reg  <= 2'd0;
            snap_reg   <= 16'h0000;
            active_reg <= 1'b0;
            tick_reg   <= 1'b0;
        end else begin
            pre_reg    <= pre_next;
            digit_reg  <= digit_next;
            snap_reg   <= snap_next;
            active_reg <= active_next;
            tick_reg   <= tick_next;
        end
    end

    // Per-digit glyphs; upper digits may blank when everything above and including them is zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign digit_seg[gi] = hex7(snap_reg[3:0]);
            end else begin : g_upper
                logic blank;
                assign blank = BLANK_LZ && (snap_reg[15:4*gi] == '0);
                assign digit_seg[gi] = blank ? 7'h7F : hex7(snap_reg[4*gi +: 4]);
            end
        end
    endgenerate

    assign disp_anode = active_reg ? ~(4'b0001 << digit_reg) : 4'hF;
    assign disp_seg   = active_reg ? {~dp_mask[digit_reg], digit_seg[digit_reg]} : 8'hFF;
    assign frame_tick = tick_reg;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench: stimulus queues the expected per-cycle display for two
// instances (no blanking / leading-zero blanking); a negedge monitor checks them.
module tb_seg7_scan_display;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  disp_clock_count = 8'h00;
    logic [8:0]  pc = 9'h000;
    logic [31:0] reg_value = 32'h0000_1234;
    logic [1:0]  sel = 2'd0;
    logic [3:0]  dp_mask = 4'h0;

    logic [3:0] an0, an1;
    logic [7:0] sg0, sg1;
    logic       tk0, tk1;

    always #5 clock = ~clock;

    seg7_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (
        .clock(clock), .reset_n(reset_n), .disp_clock_count(disp_clock_count),
        .pc(pc), .reg_value(reg_value), .sel(sel), .dp_mask(dp_mask),
        .disp_anode(an0), .disp_seg(sg0), .frame_tick(tk0)
    );

    seg7_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut1 (
        .clock(clock), .reset_n(reset_n), .disp_clock_count(disp_clock_count),
        .pc(pc), .reg_value(reg_value), .sel(sel), .dp_mask(dp_mask),
        .disp_anode(an1), .disp_seg(sg1), .frame_tick(tk1)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] s0;
        logic [7:0] s1;
        logic       tk;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    // Monitor: the display presents a new output every cycle.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("anode0", {4'h0, an0}, {4'h0, e.an});
            check("seg0", sg0, e.s0);
            check("tick0", {7'h0, tk0}, {7'h0, e.tk});
            check("anode1", {4'h0, an1}, {4'h0, e.an});
            check("seg1", sg1, e.s1);
            check("tick1", {7'h0, tk1}, {7'h0, e.tk});
            $display("cyc %0d anode=%h seg0=%h seg1=%h tick=%b", cyc, an0, sg0, sg1, tk0);
            cyc++;
        end
    end

    task automatic show(input logic [3:0] an, input logic [7:0] s0,
                        input logic [7:0] s1, input logic tk);
        @(posedge clock);
        #1;
        q.push_back('{an: an, s0: s0, s1: s1, tk: tk});
    endtask

    // One full frame; s0/s1 pack the expected segments as {d3,d2,d1,d0}.
    task automatic frame(input logic [31:0] s0, input logic [31:0] s1, input logic tk,
                         input bit mid, input logic [31:0] mid_val);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                show(an_tab[d], s0[8*d +: 8], s1[8*d +: 8], tk && d == 0 && c == 0);
                if (mid && d == 1 && c == 0) reg_value = mid_val;
            end
        end
    endtask

    initial begin
        // Held in reset: blank display, no tick.
        show(4'hF, 8'hFF, 8'hFF, 1'b0);
        show(4'hF, 8'hFF, 8'hFF, 1'b0);
        reset_n = 1'b1;
        frame(32'hF9A4B099, 32'hF9A4B099, 1'b1, 1'b0, 32'h0);
        frame(32'hF9A4B099, 32'hF9A4B099, 1'b1, 1'b0, 32'h0);
        sel = 2'd1;
        reg_value = 32'hABCD_0000;
        frame(32'h8883C6A1, 32'h8883C6A1, 1'b1, 1'b0, 32'h0);
        sel = 2'd0;
        reg_value = 32'h0000_1234;
        // Mid-frame data change must not tear the current frame.
        frame(32'hF9A4B099, 32'hF9A4B099, 1'b1, 1'b1, 32'h0000_FFFF);
        frame(32'h8E8E8E8E, 32'h8E8E8E8E, 1'b1, 1'b0, 32'h0);
        sel = 2'd2;
        pc = 9'h004;
        frame(32'hC0C0C099, 32'hFFFFFF99, 1'b1, 1'b0, 32'h0);
        pc = 9'h000;
        frame(32'hC0C0C0C0, 32'hFFFFFFC0, 1'b1, 1'b0, 32'h0);
        sel = 2'd3;
        disp_clock_count = 8'h5A;
        dp_mask = 4'b0010;
        frame(32'hC0C01288, 32'hFFFF1288, 1'b1, 1'b0, 32'h0);
        // Reset asserted while digit 2 is lit.
        for (int c = 0; c < 4; c++) show(4'hE, 8'h88, 8'h88, c == 0);
        for (int c = 0; c < 4; c++) show(4'hD, 8'h12, 8'h12, 1'b0);
        show(4'hB, 8'hC0, 8'hFF, 1'b0);
        reset_n = 1'b0;
        show(4'hF, 8'hFF, 8'hFF, 1'b0);
        show(4'hF, 8'hFF, 8'hFF, 1'b0);
        reset_n = 1'b1;
        frame(32'hC0C01288, 32'hFFFF1288, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
